// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block sequencer.
package sha256_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int ADDR_W          = 4;
    localparam int IDX_W           = 5;
    localparam int BLK_CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_FEED      = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_ME   = 3'd4,
        ST_COMP      = 3'd5,
        ST_WAIT_COMP = 3'd6,
        ST_DONE      = 3'd7
    } ctrl_state_e;

endpackage

// File: rtl/sha256_word_buf.sv
// 16-word block buffer: one write port for loading, one combinational read port for replay.
module sha256_word_buf
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [WORDS_PER_BLOCK-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sha256_block_ctrl.sv
// Block sequencer: buffers 16 words, replays them into the expander, then runs compression per block.
// Define SHA_CTRL_TIMEOUT_EN to add a per-wait-state watchdog and the sticky err output.
module sha256_block_ctrl
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH = 32
`ifdef SHA_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  me_wr_en,
    output logic [IDX_W-1:0]      me_wr_idx,
    output logic [DATA_WIDTH-1:0] me_wr_data,
    output logic                  me_start,
    input  logic                  me_done,
    output logic                  comp_start,
    output logic                  comp_first,
    input  logic                  comp_done,
    output logic                  digest_valid,
    output logic [2:0]            o_state,
    output logic [BLK_CNT_W-1:0]  o_block_cnt,
    output logic                  busy
`ifdef SHA_CTRL_TIMEOUT_EN
  , output logic                  err
`endif
);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_W-1:0]     word_cnt_q, word_cnt_d;
    logic [BLK_CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic                  last_q, last_d;
    logic                  in_ready_q;
    logic                  buf_we;
    logic                  hs;
`ifdef SHA_CTRL_TIMEOUT_EN
    logic [8:0]            wdog_q, wdog_d;
    logic                  err_q, err_d;
`endif

    assign hs = in_valid & in_ready_q;

    // word_cnt doubles as load write pointer and feed read pointer; it is 0 whenever idle.
    sha256_word_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_addr_i (word_cnt_q),
        .wr_data_i (in_data),
        .rd_addr_i (word_cnt_q),
        .rd_data_o (me_wr_data)
    );

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        last_d       = last_q;
        buf_we       = 1'b0;
        me_wr_en     = 1'b0;
        me_start     = 1'b0;
        comp_start   = 1'b0;
        comp_first   = 1'b0;
        digest_valid = 1'b0;
`ifdef SHA_CTRL_TIMEOUT_EN
        wdog_d       = '0;
        err_d        = hs ? 1'b0 : err_q;
`endif
        case (state_q)
            ST_IDLE: if (hs) begin
                buf_we     = 1'b1;
                word_cnt_d = ADDR_W'(1);
                state_d    = ST_LOAD;
            end
            ST_LOAD: if (hs) begin
                buf_we     = 1'b1;
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == ADDR_W'(WORDS_PER_BLOCK - 1)) begin
                    last_d  = in_last;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                me_wr_en   = 1'b1;
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == ADDR_W'(WORDS_PER_BLOCK - 1)) state_d = ST_START;
            end
            ST_START: begin
                me_start = 1'b1;
                state_d  = ST_WAIT_ME;
            end
            ST_WAIT_ME: if (me_done) state_d = ST_COMP;
            ST_COMP: begin
                comp_start = 1'b1;
                comp_first = (blk_cnt_q == '0);
                state_d    = ST_WAIT_COMP;
            end
            ST_WAIT_COMP: if (comp_done) begin
                blk_cnt_d = blk_cnt_q + 1'b1;
                state_d   = last_q ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                blk_cnt_d    = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SHA_CTRL_TIMEOUT_EN
        // A stalled datapath aborts the whole message.
        if ((state_q == ST_WAIT_ME && !me_done) || (state_q == ST_WAIT_COMP && !comp_done)) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == 9'(TIMEOUT_CYCLES - 1)) begin
                wdog_d    = '0;
                err_d     = 1'b1;
                blk_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            blk_cnt_q  <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
`ifdef SHA_CTRL_TIMEOUT_EN
            wdog_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            last_q     <= last_d;
            in_ready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
`ifdef SHA_CTRL_TIMEOUT_EN
            wdog_q     <= wdog_d;
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign me_wr_idx   = {1'b0, word_cnt_q};
    assign o_state     = state_q;
    assign o_block_cnt = blk_cnt_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef SHA_CTRL_TIMEOUT_EN
    assign err         = err_q;
`endif

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl with a behavioural stand-in for the expander and core handshakes.
module tb_sha256_block_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_last;
    logic [31:0] in_data, me_wr_data;
    logic        me_wr_en, me_start, me_done, comp_start, comp_first, comp_done, digest_valid, busy;
    logic [4:0]  me_wr_idx;
    logic [2:0]  o_state;
    logic [7:0]  o_block_cnt;
`ifdef SHA_CTRL_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] blk_w [16];
    logic [31:0] fed   [16];
    int n_feed = 0, n_mestart = 0, n_comp = 0, n_dig = 0, idx_err = 0;

    always #5 clk = ~clk;

    sha256_block_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .me_wr_en(me_wr_en), .me_wr_idx(me_wr_idx),
        .me_wr_data(me_wr_data), .me_start(me_start), .me_done(me_done),
        .comp_start(comp_start), .comp_first(comp_first), .comp_done(comp_done),
        .digest_valid(digest_valid), .o_state(o_state), .o_block_cnt(o_block_cnt), .busy(busy)
`ifdef SHA_CTRL_TIMEOUT_EN
      , .err(err)
`endif
    );

    // Event recorder: expander writes must arrive in index order 0..15.
    always @(negedge clk) begin
        if (me_wr_en === 1'b1) begin
            if (me_wr_idx !== 5'(n_feed % 16)) idx_err++;
            fed[me_wr_idx[3:0]] = me_wr_data;
            n_feed++;
        end
        if (me_start === 1'b1)     n_mestart++;
        if (comp_start === 1'b1)   n_comp++;
        if (digest_valid === 1'b1) n_dig++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        me_done = 1'b0; comp_done = 1'b0;
        step(); step();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_cnt",   32'(o_block_cnt), 32'd0);
        chk("rst_pulses", 32'({me_wr_en, me_start, comp_start, digest_valid}), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic send_block(input int last_idx, input bit bp);
        int  i = 0;
        int  cyc = 0;
        bit  hs;
        while (i < 16 && cyc < 400) begin
            in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = blk_w[i];
            in_last  = (i == last_idx);
            hs = in_valid && in_ready;
            step();
            cyc++;
            if (hs) i++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("send_words", 32'(i), 32'd16);
    endtask

    // Runs one block through load/feed/expand/compress and checks each stage.
    task automatic run_block(input int last_idx, input bit bp, input bit exp_first,
                             input bit exp_done, input int exp_cnt);
        int fb = n_feed, mb = n_mestart, db = n_dig, cb = n_comp, bad = 0;
        send_block(last_idx, bp);
        chk("feed_state", 32'(o_state), 32'd2);
        chk("feed_ready", 32'(in_ready), 32'd0);
        repeat (17) step();
        chk("wait_me_lat", 32'(o_state), 32'd4);
        chk("feed_count", 32'(n_feed - fb), 32'd16);
        chk("feed_idx", 32'(idx_err), 32'd0);
        for (int k = 0; k < 16; k++) if (fed[k] !== blk_w[k]) bad++;
        chk("feed_data", 32'(bad), 32'd0);
        chk("me_start_cnt", 32'(n_mestart - mb), 32'd1);
        comp_done = 1'b1; step(); comp_done = 1'b0;
        chk("stray_comp_done", 32'(o_state), 32'd4);
        me_done = 1'b1; step(); me_done = 1'b0;
        chk("comp_state", 32'(o_state), 32'd5);
        chk("comp_start", 32'(comp_start), 32'd1);
        chk("comp_first", 32'(comp_first), 32'(exp_first));
        step(); step();
        chk("wait_comp", 32'(o_state), 32'd6);
        chk("comp_once", 32'(n_comp - cb), 32'd1);
        comp_done = 1'b1; step(); comp_done = 1'b0;
        chk("blk_cnt", 32'(o_block_cnt), 32'(exp_cnt));
        if (exp_done) begin
            chk("done_state", 32'(o_state), 32'd7);
            chk("digest_valid", 32'(digest_valid), 32'd1);
            step();
            chk("idle_after", 32'(o_state), 32'd0);
            chk("cnt_clear", 32'(o_block_cnt), 32'd0);
            chk("digest_once", 32'(n_dig - db), 32'd1);
        end else begin
            chk("reload_state", 32'(o_state), 32'd1);
            step();
            chk("reload_ready", 32'(in_ready), 32'd1);
            chk("no_digest", 32'(n_dig - db), 32'd0);
        end
    endtask

    initial begin
        int d0;
        do_reset();

        // "abc" padded single block
        for (int k = 0; k < 16; k++) blk_w[k] = 32'h0;
        blk_w[0] = 32'h61626380; blk_w[15] = 32'h00000018;
        run_block(15, 1'b0, 1'b1, 1'b1, 1);

        // two-block message
        d0 = n_dig;
        for (int k = 0; k < 16; k++) blk_w[k] = 32'h10000000 + 32'(k) * 32'h01010101;
        run_block(99, 1'b0, 1'b1, 1'b0, 1);
        for (int k = 0; k < 16; k++) blk_w[k] = 32'hF0000000 - 32'(k);
        run_block(15, 1'b0, 1'b0, 1'b1, 2);
        chk("two_blk_digests", 32'(n_dig - d0), 32'd1);

        // random backpressure
        for (int k = 0; k < 16; k++) blk_w[k] = 32'hA5000000 | 32'(k);
        run_block(15, 1'b1, 1'b1, 1'b1, 1);

        // in_last on word 7 only must not end the message
        for (int k = 0; k < 16; k++) blk_w[k] = 32'h00C0FFEE ^ (32'(k) << 24);
        run_block(7, 1'b0, 1'b1, 1'b0, 1);

        // reset while waiting for the expander
        do_reset();
        d0 = n_dig;
        send_block(15, 1'b0);
        repeat (17) step();
        chk("pre_rst_wait_me", 32'(o_state), 32'd4);
        rst_n = 1'b0; step();
        chk("abort_state", 32'(o_state), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        d0 = n_comp;
        me_done = 1'b1; comp_done = 1'b1;
        repeat (3) step();
        me_done = 1'b0; comp_done = 1'b0;
        chk("abort_no_comp", 32'(n_comp - d0), 32'd0);
        chk("abort_no_digest", 32'(n_dig), 32'd3);
        chk("abort_idle", 32'(o_state), 32'd0);

`ifdef SHA_CTRL_TIMEOUT_EN
        do_reset();
        for (int k = 0; k < 16; k++) blk_w[k] = 32'(k);
        send_block(15, 1'b0);
        repeat (17) step();
        repeat (255) step();
        chk("to_still_wait", 32'(o_state), 32'd4);
        chk("to_no_err_yet", 32'(err), 32'd0);
        step();
        chk("to_idle", 32'(o_state), 32'd0);
        chk("to_err", 32'(err), 32'd1);
        in_valid = 1'b1; in_data = 32'h1; step(); in_valid = 1'b0;
        chk("to_err_clear", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
